// File: rtl/wd_config_bank_if.sv
// Host-side register bus for the watchdog configuration bank.
// The host drives the strobes, address and write data; the bank returns registered read data.
interface wd_config_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              WREN;
    logic              RDEN;
    logic [ADDR_W-1:0] ABUS;
    logic [DATA_W-1:0] DBUS;
    logic [DATA_W-1:0] RDATA;
    logic              RVALID;

    modport master (
        output WREN,
        output RDEN,
        output ABUS,
        output DBUS,
        input  RDATA,
        input  RVALID
    );

    modport slave (
        input  WREN,
        input  RDEN,
        input  ABUS,
        input  DBUS,
        output RDATA,
        output RVALID
    );
endinterface

// File: rtl/wd_config_bank.sv
// Watchdog configuration/status bank: window/limit registers with key-unlock write protection,
// self-clearing service pulse, sticky error flag and registered readback.
//
// state | meaning
// OPEN  | protected registers writable; SERVICE write with bit 4 set locks the bank
// LOCK  | protected writes rejected; waiting for KEY_A on the KEY register
// KEY1  | KEY_A seen; the very next write must be KEY_B
// ARMED | one protected write allowed, then back to LOCK
module wd_config_bank #(
    parameter int          DATA_W = 16,
    parameter int          ADDR_W = 3,
    parameter logic [15:0] KEY_A  = 16'hA5A5,
    parameter logic [15:0] KEY_B  = 16'h5A5A
) (
    input  logic              CLK,
    input  logic              RST,
    wd_config_bank_if.slave   bus,
    output logic [DATA_W-1:0] FWLEN,
    output logic [DATA_W-1:0] SWLEN,
    output logic [DATA_W-1:0] RST_LMT,
    output logic              WDSRVC,
    output logic              INIT,
    output logic [2:0]        FLSTAT,
    output logic              LOCKED,
    output logic              CFG_ERR,
    output logic              VIOL
);

    localparam int NUM_SCR = (1 << ADDR_W) - 6;

    localparam logic [ADDR_W-1:0] A_FWLEN   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_SWLEN   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_SERVICE = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_RSTLMT  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_KEY     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(5);

    localparam logic [DATA_W-1:0] KEY_A_W = DATA_W'(KEY_A);
    localparam logic [DATA_W-1:0] KEY_B_W = DATA_W'(KEY_B);

    typedef enum logic [1:0] {
        ST_OPEN  = 2'b00,
        ST_LOCK  = 2'b01,
        ST_KEY1  = 2'b10,
        ST_ARMED = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_fwlen;
    logic [DATA_W-1:0] r_swlen;
    logic [DATA_W-1:0] r_rst_lmt;
    logic              r_init;
    logic [2:0]        r_flstat;
    logic              r_wdsrvc;
    logic              r_cfg_err;
    logic              r_viol;
    logic [DATA_W-1:0] r_scratch [NUM_SCR];
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    logic              w_is_prot;
    logic              w_is_key;
    logic              w_wr_srv;
    logic              w_wr_stat;
    logic              w_prot_ok;
    logic              w_viol;
    logic [DATA_W-1:0] w_rd_data;

    assign w_is_prot = (bus.ABUS == A_FWLEN) || (bus.ABUS == A_SWLEN) || (bus.ABUS == A_RSTLMT);
    assign w_is_key  = (bus.ABUS == A_KEY);
    assign w_wr_srv  = bus.WREN && (bus.ABUS == A_SERVICE);
    assign w_wr_stat = bus.WREN && (bus.ABUS == A_STATUS);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_OPEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prot_ok   = 1'b0;
        w_viol      = 1'b0;
        if (bus.WREN) begin
            case (r_state)
                ST_OPEN: begin
                    w_prot_ok = w_is_prot;
                    if ((bus.ABUS == A_SERVICE) && bus.DBUS[4]) begin
                        w_state_nxt = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (w_is_key) begin
                        if (bus.DBUS == KEY_A_W) begin
                            w_state_nxt = ST_KEY1;
                        end else begin
                            w_viol = 1'b1;
                        end
                    end else if (w_is_prot) begin
                        w_viol = 1'b1;
                    end
                end
                ST_KEY1: begin
                    if (w_is_key && (bus.DBUS == KEY_B_W)) begin
                        w_state_nxt = ST_ARMED;
                    end else begin
                        // Broken sequence drops back to LOCK, and the offending write
                        // is then judged as a LOCK-state write (KEY_A restarts the sequence).
                        w_viol      = 1'b1;
                        w_state_nxt = (w_is_key && (bus.DBUS == KEY_A_W)) ? ST_KEY1 : ST_LOCK;
                    end
                end
                ST_ARMED: begin
                    if (w_is_prot) begin
                        w_prot_ok   = 1'b1;
                        w_state_nxt = ST_LOCK;
                    end
                end
                default: w_state_nxt = ST_OPEN;
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (bus.ABUS)
            A_FWLEN:   w_rd_data = r_fwlen;
            A_SWLEN:   w_rd_data = r_swlen;
            A_RSTLMT:  w_rd_data = r_rst_lmt;
            A_SERVICE: begin
                w_rd_data[4]   = r_init;
                w_rd_data[2:0] = r_flstat;
            end
            A_KEY:     w_rd_data = '0;
            A_STATUS:  begin
                w_rd_data[3]   = r_cfg_err;
                w_rd_data[2]   = LOCKED;
                w_rd_data[1:0] = r_state;
            end
            default: begin
                for (int i = 0; i < NUM_SCR; i++) begin
                    if (bus.ABUS == ADDR_W'(i + 6)) begin
                        w_rd_data = r_scratch[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fwlen   <= '0;
            r_swlen   <= '0;
            r_rst_lmt <= '0;
            r_init    <= 1'b0;
            r_flstat  <= '0;
            r_wdsrvc  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_viol    <= 1'b0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            for (int i = 0; i < NUM_SCR; i++) begin
                r_scratch[i] <= '0;
            end
        end else begin
            if (w_prot_ok) begin
                if (bus.ABUS == A_FWLEN)  r_fwlen   <= bus.DBUS;
                if (bus.ABUS == A_SWLEN)  r_swlen   <= bus.DBUS;
                if (bus.ABUS == A_RSTLMT) r_rst_lmt <= bus.DBUS;
            end
            if (w_wr_srv) begin
                r_flstat <= bus.DBUS[2:0];
                r_init   <= r_init | bus.DBUS[4];
            end
            r_wdsrvc <= w_wr_srv && bus.DBUS[3];
            r_viol   <= w_viol;
            // A violation in the same cycle as a clear request keeps the flag set.
            if (w_viol) begin
                r_cfg_err <= 1'b1;
            end else if (w_wr_stat && bus.DBUS[2]) begin
                r_cfg_err <= 1'b0;
            end
            for (int i = 0; i < NUM_SCR; i++) begin
                if (bus.WREN && (bus.ABUS == ADDR_W'(i + 6))) begin
                    r_scratch[i] <= bus.DBUS;
                end
            end
            r_rvalid <= bus.RDEN;
            if (bus.RDEN) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    assign FWLEN      = r_fwlen;
    assign SWLEN      = r_swlen;
    assign RST_LMT    = r_rst_lmt;
    assign WDSRVC     = r_wdsrvc;
    assign INIT       = r_init;
    assign FLSTAT     = r_flstat;
    assign LOCKED     = (r_state == ST_LOCK) || (r_state == ST_KEY1);
    assign CFG_ERR    = r_cfg_err;
    assign VIOL       = r_viol;
    assign bus.RDATA  = r_rdata;
    assign bus.RVALID = r_rvalid;

endmodule

// File: tb/tb_wd_config_bank.sv
// Table-driven bench for wd_config_bank: one bus operation per row with expected outputs,
// read data checked through a scoreboard queue, plus a reset-while-armed sequence.
module tb_wd_config_bank;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] FWLEN, SWLEN, RST_LMT;
    logic          WDSRVC, INIT, LOCKED, CFG_ERR, VIOL;
    logic [2:0]    FLSTAT;

    always #5 CLK = ~CLK;

    wd_config_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wd_config_bank #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus.slave),
        .FWLEN   (FWLEN),
        .SWLEN   (SWLEN),
        .RST_LMT (RST_LMT),
        .WDSRVC  (WDSRVC),
        .INIT    (INIT),
        .FLSTAT  (FLSTAT),
        .LOCKED  (LOCKED),
        .CFG_ERR (CFG_ERR),
        .VIOL    (VIOL)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] fw;
        logic [15:0] sw;
        logic [15:0] rl;
        logic        in;
        logic [2:0]  fl;
        logic        lk;
        logic        er;
        logic        vl;
        logic        sv;
        logic [15:0] rdx;
    } vec_t;

    vec_t        vt[$];
    logic [15:0] sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic rd, input logic [2:0] a, input logic [15:0] d,
                       input logic [15:0] fw, input logic [15:0] sw, input logic [15:0] rl,
                       input logic in, input logic [2:0] fl, input logic lk, input logic er,
                       input logic vl, input logic sv, input logic [15:0] rdx);
        vec_t v;
        v.wr = wr; v.rd = rd; v.a = a; v.d = d;
        v.fw = fw; v.sw = sw; v.rl = rl; v.in = in; v.fl = fl;
        v.lk = lk; v.er = er; v.vl = vl; v.sv = sv; v.rdx = rdx;
        vt.push_back(v);
    endtask

    task automatic check_read(input string name);
        logic [15:0] e;
        if (bus.RVALID) begin
            if (sb.size() == 0) begin
                chk({name, "_unexpected_rvalid"}, 64'(bus.RDATA), 64'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk({name, "_rdata"}, 64'(bus.RDATA), 64'(e));
            end
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge CLK);
        bus.WREN = v.wr;
        bus.RDEN = v.rd;
        bus.ABUS = v.a;
        bus.DBUS = v.d;
        if (v.rd) sb.push_back(v.rdx);
        @(posedge CLK);
        #1;
        chk({name, "_outs"},
            64'({FWLEN, SWLEN, RST_LMT, INIT, FLSTAT, LOCKED, CFG_ERR, VIOL, WDSRVC, bus.RVALID}),
            64'({v.fw, v.sw, v.rl, v.in, v.fl, v.lk, v.er, v.vl, v.sv, v.rd}));
        check_read(name);
        bus.WREN = 1'b0;
        bus.RDEN = 1'b0;
    endtask

    initial begin
        vec_t v;
        //   wr rd a  data      fwlen     swlen     rstlmt    in fl    lk er vl sv rdata
        add(1, 0, 0, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 0, 3'd0, 0, 0, 0, 0, 16'h0000);
        add(0, 1, 0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 0, 3'd0, 0, 0, 0, 0, 16'h0100);
        add(1, 0, 2, 16'h0010, 16'h0100, 16'h0000, 16'h0000, 1, 3'd0, 1, 0, 0, 0, 16'h0000);
        add(1, 0, 0, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 1, 3'd0, 1, 1, 1, 0, 16'h0000);
        add(0, 0, 0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 1, 3'd0, 1, 1, 0, 0, 16'h0000);
        add(0, 1, 5, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 1, 3'd0, 1, 1, 0, 0, 16'h000D);
        add(1, 0, 4, 16'hA5A5, 16'h0100, 16'h0000, 16'h0000, 1, 3'd0, 1, 1, 0, 0, 16'h0000);
        add(1, 0, 4, 16'h5A5A, 16'h0100, 16'h0000, 16'h0000, 1, 3'd0, 0, 1, 0, 0, 16'h0000);
        add(1, 0, 1, 16'h0033, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 1, 0, 0, 16'h0000);
        add(1, 0, 1, 16'h0044, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 1, 1, 0, 16'h0000);
        add(0, 1, 1, 16'h0000, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 1, 0, 0, 16'h0033);
        add(1, 0, 4, 16'hA5A5, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 1, 0, 0, 16'h0000);
        add(1, 0, 6, 16'h1234, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 1, 1, 0, 16'h0000);
        add(0, 1, 6, 16'h0000, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 1, 0, 0, 16'h1234);
        add(0, 1, 5, 16'h0000, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 1, 0, 0, 16'h000D);
        add(1, 0, 5, 16'h0004, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 0, 0, 0, 16'h0000);
        add(0, 1, 5, 16'h0000, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 0, 0, 0, 16'h0005);
        add(1, 0, 2, 16'h0008, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 0, 0, 1, 16'h0000);
        add(1, 0, 2, 16'h0008, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 0, 0, 1, 16'h0000);
        add(0, 0, 0, 16'h0000, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 0, 0, 0, 16'h0000);
        add(0, 1, 2, 16'h0000, 16'h0100, 16'h0033, 16'h0000, 1, 3'd0, 1, 0, 0, 0, 16'h0010);
        add(1, 0, 2, 16'h0005, 16'h0100, 16'h0033, 16'h0000, 1, 3'd5, 1, 0, 0, 0, 16'h0000);
        add(0, 1, 2, 16'h0000, 16'h0100, 16'h0033, 16'h0000, 1, 3'd5, 1, 0, 0, 0, 16'h0015);
        add(1, 0, 4, 16'h1111, 16'h0100, 16'h0033, 16'h0000, 1, 3'd5, 1, 1, 1, 0, 16'h0000);
        add(1, 0, 3, 16'h00FF, 16'h0100, 16'h0033, 16'h0000, 1, 3'd5, 1, 1, 1, 0, 16'h0000);
        add(1, 0, 4, 16'hA5A5, 16'h0100, 16'h0033, 16'h0000, 1, 3'd5, 1, 1, 0, 0, 16'h0000);
        add(1, 0, 4, 16'hA5A5, 16'h0100, 16'h0033, 16'h0000, 1, 3'd5, 1, 1, 1, 0, 16'h0000);
        add(1, 0, 4, 16'h5A5A, 16'h0100, 16'h0033, 16'h0000, 1, 3'd5, 0, 1, 0, 0, 16'h0000);
        add(1, 0, 7, 16'hBEEF, 16'h0100, 16'h0033, 16'h0000, 1, 3'd5, 0, 1, 0, 0, 16'h0000);
        add(0, 1, 5, 16'h0000, 16'h0100, 16'h0033, 16'h0000, 1, 3'd5, 0, 1, 0, 0, 16'h000B);
        add(1, 0, 3, 16'h00FF, 16'h0100, 16'h0033, 16'h00FF, 1, 3'd5, 1, 1, 0, 0, 16'h0000);
        add(1, 1, 7, 16'hCAFE, 16'h0100, 16'h0033, 16'h00FF, 1, 3'd5, 1, 1, 0, 0, 16'hBEEF);
        add(0, 1, 7, 16'h0000, 16'h0100, 16'h0033, 16'h00FF, 1, 3'd5, 1, 1, 0, 0, 16'hCAFE);
        add(0, 1, 4, 16'h0000, 16'h0100, 16'h0033, 16'h00FF, 1, 3'd5, 1, 1, 0, 0, 16'h0000);
        add(1, 0, 4, 16'hA5A5, 16'h0100, 16'h0033, 16'h00FF, 1, 3'd5, 1, 1, 0, 0, 16'h0000);
        add(1, 0, 4, 16'h5A5A, 16'h0100, 16'h0033, 16'h00FF, 1, 3'd5, 0, 1, 0, 0, 16'h0000);

        RST      = 1'b1;
        bus.WREN = 1'b0;
        bus.RDEN = 1'b0;
        bus.ABUS = '0;
        bus.DBUS = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_state",
            64'({FWLEN, SWLEN, RST_LMT, INIT, FLSTAT, LOCKED, CFG_ERR, VIOL, WDSRVC, bus.RVALID}),
            64'h0);
        chk("reset_rdata", 64'(bus.RDATA), 64'h0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i], $sformatf("vec%0d", i));
        end

        // Reset while ARMED with a concurrent FWLEN write and read.
        @(negedge CLK);
        RST      = 1'b1;
        bus.WREN = 1'b1;
        bus.RDEN = 1'b1;
        bus.ABUS = 3'd0;
        bus.DBUS = 16'h0999;
        @(posedge CLK);
        #1;
        chk("armed_reset_outs",
            64'({FWLEN, SWLEN, RST_LMT, INIT, FLSTAT, LOCKED, CFG_ERR, VIOL, WDSRVC, bus.RVALID}),
            64'h0);
        chk("armed_reset_rdata", 64'(bus.RDATA), 64'h0);
        @(negedge CLK);
        RST      = 1'b0;
        bus.WREN = 1'b0;
        bus.RDEN = 1'b0;

        v = '{wr: 0, rd: 1, a: 3'd0, d: 16'h0, fw: 16'h0, sw: 16'h0, rl: 16'h0, in: 0, fl: 3'd0,
              lk: 0, er: 0, vl: 0, sv: 0, rdx: 16'h0000};
        apply(v, "post_rst_fwlen");
        v.a = 3'd5;
        apply(v, "post_rst_status");
        // Lock from a clean state: OPEN -> LOCK on INIT write; FWLEN write then rejected.
        v = '{wr: 1, rd: 0, a: 3'd2, d: 16'h0010, fw: 16'h0, sw: 16'h0, rl: 16'h0, in: 1, fl: 3'd0,
              lk: 1, er: 0, vl: 0, sv: 0, rdx: 16'h0000};
        apply(v, "relock");
        v.a = 3'd0; v.d = 16'h0777; v.er = 1; v.vl = 1;
        apply(v, "relock_reject");

        chk("scoreboard_empty", 64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wd_config_bank.md
Name: wd_config_bank

Overview:
Parametrised configuration/status register bank for the windowed watchdog.
- Holds first-window length, second-window length, service/control and reset-limit registers, plus scratch registers.
- Adds registered readback, write protection after INIT, a two-write key unlock sequence, a self-clearing watchdog service pulse and a sticky error flag.
- Sits between the host bus and the watchdog timer/fault logic.

Parameters:
DATA_W, 16, register width (min 8); all registers and DBUS/RDATA are DATA_W bits.
ADDR_W, 3, address width (min 3); addresses 6 to 2**ADDR_W-1 are scratch registers.
KEY_A, 16'hA5A5, first unlock key (zero-extended or truncated to DATA_W).
KEY_B, 16'h5A5A, second unlock key (zero-extended or truncated to DATA_W).

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
WREN  in  1  write strobe, one write per asserted cycle
RDEN  in  1  read strobe
ABUS  in  ADDR_W  register address
DBUS  in  DATA_W  write data
RDATA  out  DATA_W  read data, registered
RVALID  out  1  one-cycle pulse, RDATA valid
FWLEN  out  DATA_W  first window length (addr 0, protected)
SWLEN  out  DATA_W  second window length (addr 1, protected)
RST_LMT  out  DATA_W  reset limit (addr 3, protected)
WDSRVC  out  1  one-cycle service pulse
INIT  out  1  sticky init bit
FLSTAT  out  3  fault status field
LOCKED  out  1  high when protected writes are blocked
CFG_ERR  out  1  sticky error flag
VIOL  out  1  one-cycle pulse on a rejected write or bad key

Behaviour:
- Reset: RST=1 at a clock edge clears all registers, RDATA, RVALID, WDSRVC, VIOL, CFG_ERR and INIT. Lock FSM goes to OPEN. Reset overrides any concurrent read or write.
- Register map:
  - 0 FWLEN, 1 SWLEN, 3 RST_LMT: protected.
  - 2 SERVICE: [4] INIT, [3] WDSRVC, [2:0] FLSTAT; upper bits read 0.
  - 4 KEY: write-only, reads 0.
  - 5 STATUS: read {0.., CFG_ERR, LOCKED, state[1:0]}.
  - 6 and above: scratch.
- Lock FSM states: OPEN=00, LOCK=01, KEY1=10, ARMED=11. LOCKED output = (state != OPEN && state != ARMED).
  - OPEN: protected writes are accepted. A SERVICE write with DBUS[4]=1 moves to LOCK.
  - LOCK: a write to KEY with KEY_A moves to KEY1. A KEY write with any other value stays in LOCK, sets CFG_ERR and pulses VIOL.
  - KEY1: the next write transaction must be to KEY with KEY_B, which moves to ARMED. Any other write (any address or value) returns to LOCK, sets CFG_ERR and pulses VIOL; that other write is itself processed normally per LOCK rules.
  - ARMED: exactly one protected write is accepted, then the FSM returns to LOCK. Non-protected writes leave the FSM in ARMED.
- Protected write while LOCKED: data is dropped, CFG_ERR is set, VIOL pulses for one cycle.
- SERVICE writes are always accepted:
  - FLSTAT <= DBUS[2:0].
  - INIT <= INIT | DBUS[4]; INIT can only be cleared by reset.
  - DBUS[3]=1 makes WDSRVC =1 for exactly the cycle after the write. The stored bit always reads 0.
- STATUS write: DBUS[2]=1 clears CFG_ERR (write-1-to-clear). If a violation occurs in the same cycle, set wins. Other STATUS bits ignore writes.
- Scratch registers: plain read/write, no protection.
- Read: RDEN at edge N gives RDATA/RVALID at edge N+1 (1-cycle latency). RDATA holds its value until the next read.
  - Simultaneous RDEN and WREN to the same address returns the pre-write value.
- Outputs FWLEN, SWLEN, RST_LMT, INIT, FLSTAT update on the edge after an accepted write.
- Unused address bits: none; every address decodes to a register.

Test Plan:
- Reset, then write FWLEN=16'h0100 at addr 0 (OPEN) and read addr 0 -> FWLEN=0x0100, RDATA=0x0100 with RVALID one cycle after RDEN.
- Write SERVICE=16'h0010, then FWLEN=16'h0200 -> INIT=1, LOCKED=1, FWLEN stays 0x0100, VIOL pulses once, CFG_ERR=1.
- In LOCK: KEY=0xA5A5, KEY=0x5A5A, then SWLEN=0x0033, then SWLEN=0x0044 -> SWLEN=0x0033, LOCKED returns to 1, second write gives VIOL.
- In LOCK: KEY=0xA5A5, then scratch addr 6=0x1234 -> state LOCK, CFG_ERR=1, VIOL=1, scratch=0x1234. Then STATUS write 0x0004 -> CFG_ERR=0.
- Write SERVICE=16'h0008 twice back-to-back -> WDSRVC high exactly 2 cycles, readback bit 3 = 0. Write SERVICE=16'h0000 -> INIT stays 1.
- Assert RST during ARMED with a concurrent FWLEN write -> all outputs 0, state OPEN, write discarded.
